// File: rtl/riscv_axil_pkg.sv
// Shared AXI4-Lite response codes, channel FSM state types and the address window check
// for the CPU data memory responder.
package riscv_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   // Operands are widened to 64 bits so a window ending at the top of the address space
   // cannot wrap.
   function automatic logic in_window(input logic [63:0] addr, input logic [63:0] base,
                                      input logic [63:0] span);
      return (addr >= base) && ((addr - base) < span);
   endfunction

endpackage

// File: rtl/dmem_ram_be.sv
// Simple dual-port word RAM: one byte-enabled write port and one registered read port.
// A read and a write to the same word on the same edge return the old contents.
module dmem_ram_be #(
   parameter int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [3:0]       be_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [31:0]      wdata_i,
   input  logic             re_i,
   input  logic [IDX_W-1:0] raddr_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem [DEPTH_WORDS];

   // No reset on the array or output register so the tools map this onto block RAM.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < 4; i++) begin
            if (be_i[i]) mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
      if (re_i) rdata_o <= mem[raddr_i];
   end

endmodule

// File: rtl/axil_dmem_slave.sv
// AXI4-Lite responder holding the CPU data memory. Independent write and read FSMs share a
// byte-enabled word RAM; accesses outside the mapped window answer SLVERR.
module axil_dmem_slave
   import riscv_axil_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           DEPTH_WORDS = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [ADDR_WIDTH-1:0] s_awaddr,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [DATA_WIDTH-1:0] s_wdata,
   input  logic [3:0]            s_wstrb,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [1:0]            s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [ADDR_WIDTH-1:0] s_araddr,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [DATA_WIDTH-1:0] s_rdata,
   output logic [1:0]            s_rresp,
   output logic                  s_rvalid,
   input  logic                  s_rready
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [63:0] SPAN  = 64'(DEPTH_WORDS) * 64'd4;

   // ---------------- write channel ----------------
   wr_state_t             wr_state_q, wr_state_d;
   logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic                  awready_q, awready_d, wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  aw_hs, w_hs, wr_in_win, ram_we;

   assign aw_hs = s_awvalid && awready_q;
   assign w_hs  = s_wvalid && wready_q;

   // Payloads as seen at this edge, so a handshake arriving now can commit immediately.
   assign awaddr_d  = aw_hs ? s_awaddr : awaddr_q;
   assign wdata_d   = w_hs ? s_wdata : wdata_q;
   assign wstrb_d   = w_hs ? s_wstrb : wstrb_q;
   assign wr_in_win = in_window(64'(awaddr_d), 64'(BASE_ADDR), SPAN);

   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      awready_d  = awready_q;
      wready_d   = wready_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      ram_we     = 1'b0;
      unique case (wr_state_q)
         W_IDLE: begin
            if (aw_hs) aw_held_d = 1'b1;
            if (w_hs)  w_held_d  = 1'b1;
            if (aw_held_d && w_held_d) begin
               ram_we     = wr_in_win;
               wr_state_d = W_RESP;
               bvalid_d   = 1'b1;
               bresp_d    = wr_in_win ? RESP_OKAY : RESP_SLVERR;
               awready_d  = 1'b0;
               wready_d   = 1'b0;
            end else begin
               awready_d = !aw_held_d;
               wready_d  = !w_held_d;
            end
         end
         W_RESP: begin
            if (s_bready) begin
               wr_state_d = W_IDLE;
               bvalid_d   = 1'b0;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               awready_d  = 1'b1;
               wready_d   = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_state_q <= W_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
      end
   end

   // ---------------- read channel ----------------
   rd_state_t   rd_state_q;
   logic        arready_q, rvalid_q;
   logic [1:0]  rresp_q;
   logic        ar_hs, rd_in_win, ram_re;
   logic [31:0] ram_rdata;

   assign ar_hs     = s_arvalid && arready_q;
   assign rd_in_win = in_window(64'(s_araddr), 64'(BASE_ADDR), SPAN);
   assign ram_re    = ar_hs && rd_in_win;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rd_state_q <= R_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rresp_q    <= RESP_OKAY;
      end else begin
         unique case (rd_state_q)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (ar_hs) begin
                  rd_state_q <= R_DATA;
                  arready_q  <= 1'b0;
                  rvalid_q   <= 1'b1;
                  rresp_q    <= rd_in_win ? RESP_OKAY : RESP_SLVERR;
               end
            end
            R_DATA: begin
               if (s_rready) begin
                  rd_state_q <= R_IDLE;
                  arready_q  <= 1'b1;
                  rvalid_q   <= 1'b0;
               end
            end
         endcase
      end
   end

   dmem_ram_be #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_ram (
      .clk_i  (aclk),
      .we_i   (ram_we),
      .be_i   (wstrb_d),
      .waddr_i(IDX_W'((awaddr_d - BASE_ADDR) >> 2)),
      .wdata_i(wdata_d),
      .re_i   (ram_re),
      .raddr_i(IDX_W'((s_araddr - BASE_ADDR) >> 2)),
      .rdata_o(ram_rdata)
   );

   // The RAM output register has no reset, so the word is masked outside a valid OKAY beat.
   assign s_rdata   = (rvalid_q && rresp_q == RESP_OKAY) ? ram_rdata : '0;
   assign s_rresp   = rresp_q;
   assign s_rvalid  = rvalid_q;
   assign s_arready = arready_q;
   assign s_awready = awready_q;
   assign s_wready  = wready_q;
   assign s_bvalid  = bvalid_q;
   assign s_bresp   = bresp_q;

endmodule
